muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the register file's rs1_out/rs2_out operand values plus the destination index.
- After a fixed multi-cycle latency, drives the register file write port (rd_w, rd, rd_in).
- One operation in flight at a time; busy tells the issue logic to stall.

Parameters:
XLEN, 32, operand/result width; counter width is $clog2(XLEN)+1.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  issue request; sampled only in IDLE
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_val  input  XLEN  operand A, from register file rs1_out
rs2_val  input  XLEN  operand B, from register file rs2_out
rd_addr  input  5  destination register index
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
rd_w  output  1  register file write enable; equals done
rd  output  5  destination index, latched at start
rd_in  output  XLEN  result value, valid only while done=1

Behaviour:
- Reset: state IDLE, counter 0. busy=0, done=0, rd_w=0, rd=0, rd_in=0.
- Reset in any state aborts the operation. No write is issued.
- States:
  - IDLE: start=1 latches funct3, rd_addr and operands. Goes to DONE if a special case applies, otherwise to CALC. start=0 stays in IDLE.
  - CALC: one iteration per cycle for exactly XLEN cycles, then goes to DONE.
  - DONE: done=rd_w=1 for one cycle with the final rd_in, then returns to IDLE.
- start is ignored in CALC and DONE. A new op can be accepted on the cycle after DONE.
- Latency, with start sampled in cycle 0:
  - Normal ops: busy=1 in cycles 1..XLEN+1; done/rd_w/rd_in valid in cycle XLEN+1 (cycle 33).
  - Special cases: done in cycle 1.
- Sign handling:
  - Signed operands are converted to magnitudes at start: rs1 is signed for MULH, MULHSU, DIV and REM; rs2 is signed for MULH, DIV and REM.
  - The core is unsigned.
  - The result sign is applied in the final CALC iteration.
  - Product sign = signA XOR signB.
  - Quotient sign = signA XOR signB.
  - Remainder sign = signA.
- Multiply: shift-add over a 2*XLEN accumulator. MUL returns the low half; MULH, MULHSU and MULHU return the high half of the correctly signed 2*XLEN product.
- Divide: restoring, one quotient bit per cycle. DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases (RISC-V defined, no trap):
  - Divide by zero: quotient = all ones; remainder = rs1_val.
  - Signed overflow (DIV/REM with rs1 = 0x80000000, rs2 = 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
  - Multiply by zero takes the full latency.
- rd = 0: the op completes and rd_w pulses normally. The register file discards the write.
- Outputs are registered. rd_in holds its last value outside done, but consumers use it only when rd_w=1.
- rd and rd_in are held stable between start and done, regardless of input changes.

Decomposition:
- Shared package holds the funct3 opcode constants (MUL..REMU) and the XLEN default, reused by the decoder.
- Optional sub-module muldiv_core: the unsigned iterative datapath (accumulator, shift, subtract, counter). The top level owns the FSM, sign conversion, special cases and the write port.

Test Plan:
- MUL rs1=7, rs2=6, rd_addr=5, start in cycle 0 -> busy cycles 1..33; in cycle 33 rd_w=1, rd=5, rd_in=42; cycle 34 busy=0.
- MULH rs1=rs2=0xFFFFFFFF -> rd_in=0x00000000. MULHSU with the same operands -> rd_in=0xFFFFFFFF. MULHU with the same operands -> rd_in=0xFFFFFFFE.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU with the same operands -> 0x7FFFFFFC.
- DIVU 5/0 -> rd_in=0xFFFFFFFF in cycle 1. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1. REM with the same operands -> 0.
- start held high through a MUL with operands changing mid-op -> only one rd_w pulse, with the original result. Next op is accepted in cycle 34.
- rst asserted in cycle 10 of a DIV -> cycle 11 busy=0, no rd_w pulse. A following MUL 3*4 produces 12 in its cycle 33.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared RV32M definitions: funct3 opcodes, default width, FSM states and
// small decode helpers used by the multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_e;

    function automatic logic op_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    function automatic logic op_a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one
// step per cycle. hi/lo hold product halves or remainder/quotient.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] a_mag_i,
    input  logic [XLEN-1:0] b_mag_i,
    output logic [XLEN-1:0] hi_next_o,
    output logic [XLEN-1:0] lo_next_o,
    output logic            last_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  opnd_q;
    logic             is_div_q;
    logic [CNT_W-1:0] cnt_q;

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_shift;
    logic [XLEN:0] div_diff;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    // NOTE: every signal driven here gets a value on entry, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (is_div_q) begin
            // Non-negative difference (top bit clear) means the divisor fits.
            if (!div_diff[XLEN]) begin
                hi_d = div_diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = div_shift[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
        end else if (load_i) begin
            hi_q     <= '0;
            lo_q     <= is_div_i ? a_mag_i : b_mag_i;
            opnd_q   <= is_div_i ? b_mag_i : a_mag_i;
            is_div_q <= is_div_i;
            cnt_q    <= '0;
        end else if (step_i) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hi_next_o = hi_d;
    assign lo_next_o = lo_d;
    assign last_o    = (cnt_q == CNT_W'(XLEN - 1));

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: FSM, sign handling, RISC-V special cases and
// the register-file write port around the unsigned iterative core.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic            rd_w,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_in
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_q, neg_d;

    logic            neg_a, neg_b;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            core_load, core_step, core_last;
    logic [XLEN-1:0] hi_next, lo_next;
    logic [2*XLEN-1:0] prod_signed;

    assign neg_a = op_a_signed(funct3) & rs1_val[XLEN-1];
    assign neg_b = op_b_signed(funct3) & rs2_val[XLEN-1];
    assign a_mag = neg_a ? -rs1_val : rs1_val;
    assign b_mag = neg_b ? -rs2_val : rs2_val;

    assign prod_signed = neg_q ? -{hi_next, lo_next} : {hi_next, lo_next};

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        result_d  = result_q;
        neg_d     = neg_q;
        core_load = 1'b0;
        core_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = funct3;
                    rd_d  = rd_addr;
                    neg_d = op_is_rem(funct3) ? neg_a : (neg_a ^ neg_b);
                    if (op_is_div(funct3) && (rs2_val == '0)) begin
                        result_d = op_is_rem(funct3) ? rs1_val : '1;
                        state_d  = ST_DONE;
                    end else if (op_is_div(funct3) && op_b_signed(funct3) &&
                                 (rs1_val == MIN_INT) && (rs2_val == '1)) begin
                        result_d = op_is_rem(funct3) ? '0 : MIN_INT;
                        state_d  = ST_DONE;
                    end else begin
                        core_load = 1'b1;
                        state_d   = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                core_step = 1'b1;
                // Sign is folded in on the last step so DONE drives the final value.
                if (core_last) begin
                    unique case (op_q)
                        F3_MUL:                        result_d = prod_signed[XLEN-1:0];
                        F3_MULH, F3_MULHSU, F3_MULHU:  result_d = prod_signed[2*XLEN-1:XLEN];
                        F3_DIV, F3_DIVU:               result_d = neg_q ? -lo_next : lo_next;
                        default:                       result_d = neg_q ? -hi_next : hi_next;
                    endcase
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= F3_MUL;
            rd_q     <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            neg_q    <= neg_d;
        end
    end

    muldiv_core #(.XLEN(XLEN)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load_i    (core_load),
        .step_i    (core_step),
        .is_div_i  (op_is_div(funct3)),
        .a_mag_i   (a_mag),
        .b_mag_i   (b_mag),
        .hi_next_o (hi_next),
        .lo_next_o (lo_next),
        .last_o    (core_last)
    );

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign rd_w  = done;
    assign rd    = rd_q;
    assign rd_in = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit plus hand-written sequences
// for held start, mid-operation reset and back-to-back issue.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  rd_addr;
    logic        busy, done, rd_w;
    logic [4:0]  rd;
    logic [31:0] rd_in;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done),
        .rd_w    (rd_w),
        .rd      (rd),
        .rd_in   (rd_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Issues one op in cycle 0 and watches cycles 1..36 (bounded).
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input int lat,
                          output logic [31:0] res, output logic [4:0] rd_seen,
                          output int first, output int pulses, output int busy_err);
        @(posedge clk); #1;
        funct3 = f3; rs1_val = a; rs2_val = b; rd_addr = d; start = 1'b1;
        first = -1; pulses = 0; busy_err = 0; res = 'x; rd_seen = 'x;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) start = 1'b0;
            if (rd_w) begin
                pulses++;
                if (first < 0) begin
                    first   = cyc;
                    res     = rd_in;
                    rd_seen = rd;
                end
            end
            if (busy !== (cyc <= lat)) busy_err++;
            if (done !== rd_w) busy_err++;
        end
    endtask

    initial begin
        logic [31:0] res;
        logic [4:0]  rd_seen;
        int first, pulses, errs;

        rst = 1'b1; start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset busy",  {31'd0, busy}, 32'd0);
        check("reset done",  {31'd0, done}, 32'd0);
        check("reset rd_w",  {31'd0, rd_w}, 32'd0);
        check("reset rd",    {27'd0, rd},   32'd0);
        check("reset rd_in", rd_in,         32'd0);

        vecs.push_back(vec_t'{F3_MUL,    32'd7,        32'd6,        5'd5,  32'd42,       33});
        vecs.push_back(vec_t'{F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000, 33});
        vecs.push_back(vec_t'{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFF, 33});
        vecs.push_back(vec_t'{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 33});
        vecs.push_back(vec_t'{F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 33});
        vecs.push_back(vec_t'{F3_REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33});
        vecs.push_back(vec_t'{F3_DIVU,   32'hFFFFFFF9, 32'd2,        5'd7,  32'h7FFFFFFC, 33});
        vecs.push_back(vec_t'{F3_REMU,   32'hFFFFFFF9, 32'd2,        5'd8,  32'd1,        33});
        vecs.push_back(vec_t'{F3_DIVU,   32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1});
        vecs.push_back(vec_t'{F3_REMU,   32'd5,        32'd0,        5'd11, 32'd5,        1});
        vecs.push_back(vec_t'{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1});
        vecs.push_back(vec_t'{F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        1});
        vecs.push_back(vec_t'{F3_MUL,    32'd0,        32'h12345678, 5'd14, 32'd0,        33});
        vecs.push_back(vec_t'{F3_MULH,   32'h80000000, 32'd2,        5'd15, 32'hFFFFFFFF, 33});
        vecs.push_back(vec_t'{F3_MUL,    32'hFFFFFFFD, 32'd5,        5'd16, 32'hFFFFFFF1, 33});
        vecs.push_back(vec_t'{F3_DIV,    32'hFFFFFFFB, 32'd0,        5'd17, 32'hFFFFFFFF, 1});
        vecs.push_back(vec_t'{F3_REM,    32'hFFFFFFFB, 32'd0,        5'd18, 32'hFFFFFFFB, 1});
        vecs.push_back(vec_t'{F3_DIV,    32'd100,      32'hFFFFFFF9, 5'd19, 32'hFFFFFFF2, 33});
        vecs.push_back(vec_t'{F3_REM,    32'd100,      32'hFFFFFFF9, 5'd20, 32'd2,        33});
        vecs.push_back(vec_t'{F3_MUL,    32'd3,        32'd5,        5'd0,  32'd15,       33});
        vecs.push_back(vec_t'{F3_MULH,   32'h7FFFFFFF, 32'h7FFFFFFF, 5'd21, 32'h3FFFFFFF, 33});
        vecs.push_back(vec_t'{F3_DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd22, 32'd0,        33});
        vecs.push_back(vec_t'{F3_REMU,   32'h80000000, 32'hFFFFFFFF, 5'd23, 32'h80000000, 33});

        foreach (vecs[i]) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].lat,
                   res, rd_seen, first, pulses, errs);
            check($sformatf("v%0d result", i),      res,               vecs[i].exp);
            check($sformatf("v%0d rd", i),          {27'd0, rd_seen},  {27'd0, vecs[i].rd});
            check($sformatf("v%0d done cycle", i),  first,             vecs[i].lat);
            check($sformatf("v%0d pulse count", i), pulses,            32'd1);
            check($sformatf("v%0d busy profile", i), errs,             32'd0);
        end

        // start held high with operands churning during a MUL 7*6.
        @(posedge clk); #1;
        funct3 = F3_MUL; rs1_val = 32'd7; rs2_val = 32'd6; rd_addr = 5'd5; start = 1'b1;
        first = -1; pulses = 0; errs = 0;
        for (int cyc = 1; cyc <= 33; cyc++) begin
            @(posedge clk); #1;
            if (rd_w) begin
                pulses++;
                if (first < 0) begin first = cyc; res = rd_in; rd_seen = rd; end
            end
            if (busy !== 1'b1) errs++;
            if (rd !== 5'd5) errs++;
            funct3 = 3'($urandom_range(0, 7));
            rs1_val = $urandom; rs2_val = $urandom; rd_addr = 5'($urandom_range(0, 31));
        end
        check("held start result",  res,              32'd42);
        check("held start rd",      {27'd0, rd_seen}, 32'd5);
        check("held start cycle",   first,            32'd33);
        check("held start pulses",  pulses,           32'd1);
        check("held start busy/rd", errs,             32'd0);
        @(posedge clk); #1;
        check("cycle 34 idle", {31'd0, busy}, 32'd0);
        funct3 = F3_MUL; rs1_val = 32'd2; rs2_val = 32'd9; rd_addr = 5'd7;
        @(posedge clk); #1;
        check("cycle 35 accepted", {31'd0, busy}, 32'd1);
        start = 1'b0; rs1_val = 32'h55555555; rs2_val = 32'h0F0F0F0F; rd_addr = 5'd30;
        first = -1; pulses = 0;
        for (int cyc = 36; cyc <= 70; cyc++) begin
            @(posedge clk); #1;
            if (rd_w) begin
                pulses++;
                if (first < 0) begin first = cyc; res = rd_in; rd_seen = rd; end
            end
        end
        check("second op result", res,              32'd18);
        check("second op rd",     {27'd0, rd_seen}, 32'd7);
        check("second op cycle",  first,            32'd67);
        check("second op pulses", pulses,           32'd1);

        // Reset in cycle 10 of a DIV aborts it without a write.
        @(posedge clk); #1;
        funct3 = F3_DIV; rs1_val = 32'd100; rs2_val = 32'd7; rd_addr = 5'd9; start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) start = 1'b0;
            if (cyc == 10) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy",  {31'd0, busy}, 32'd0);
        check("abort done",  {31'd0, done}, 32'd0);
        check("abort rd",    {27'd0, rd},   32'd0);
        check("abort rd_in", rd_in,         32'd0);
        pulses = 0;
        for (int cyc = 12; cyc <= 50; cyc++) begin
            @(posedge clk); #1;
            if (rd_w) pulses++;
        end
        check("abort no write", pulses, 32'd0);

        run_op(F3_MUL, 32'd3, 32'd4, 5'd4, 33, res, rd_seen, first, pulses, errs);
        check("post-reset MUL result", res,    32'd12);
        check("post-reset MUL cycle",  first,  32'd33);
        check("post-reset MUL pulses", pulses, 32'd1);
        check("post-reset MUL busy",   errs,   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
